// File: rtl/mdu_pkg.sv
// Shared MDU operation encoding, used by E-stage control decode, the hazard unit and the MDU.
package mdu_pkg;

  typedef enum logic [3:0] {
    OpNone  = 4'd0,
    OpMult  = 4'd1,
    OpMultu = 4'd2,
    OpDiv   = 4'd3,
    OpDivu  = 4'd4,
    OpMfhi  = 4'd5,
    OpMflo  = 4'd6,
    OpMthi  = 4'd7,
    OpMtlo  = 4'd8
  } mdu_op_e;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OpMult) || (op == OpMultu);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit {HI,LO} result for MULT/MULTU/DIV/DIVU, including the
// divide-by-zero (keep current HI/LO) and signed overflow rules.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [63:0] result_o
);

  logic signed [63:0] a_sx, b_sx, prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] quo_s, rem_s;
  logic        [31:0] quo_u, rem_u;
  logic               b_zero, div_ovf;

  assign a_sx    = {{32{a_i[31]}}, a_i};
  assign b_sx    = {{32{b_i[31]}}, b_i};
  assign prod_s  = a_sx * b_sx;
  assign prod_u  = {32'd0, a_i} * {32'd0, b_i};
  assign b_zero  = (b_i == 32'd0);
  assign div_ovf = (a_i == 32'h8000_0000) && (b_i == 32'hffff_ffff);

  // Operands are forced to safe values whenever the quotient is discarded anyway.
  always_comb begin
    quo_s = 32'sd0;
    rem_s = 32'sd0;
    quo_u = 32'd0;
    rem_u = 32'd0;
    if (!b_zero && !div_ovf) begin
      quo_s = $signed(a_i) / $signed(b_i);
      rem_s = $signed(a_i) % $signed(b_i);
    end
    if (!b_zero) begin
      quo_u = a_i / b_i;
      rem_u = a_i % b_i;
    end
  end

  always_comb begin
    result_o = {hi_i, lo_i};
    case (mdu_op_e'(op_i))
      OpMult:  result_o = prod_s;
      OpMultu: result_o = prod_u;
      OpDiv: begin
        if (div_ovf) begin
          result_o = {32'd0, 32'h8000_0000};
        end else if (!b_zero) begin
          result_o = {rem_s, quo_s};
        end
      end
      OpDivu: begin
        if (!b_zero) begin
          result_o = {rem_u, quo_u};
        end
      end
      default: result_o = {hi_i, lo_i};
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs MULT/DIV with fixed latency
// and serves MFHI/MFLO/MTHI/MTLO.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] out
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [63:0]     arith_result;

  mdu_arith u_arith (
    .op_i     (op),
    .a_i      (A),
    .b_i      (B),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .result_o (arith_result)
  );

  // RUN is simply a non-zero counter.
  assign busy  = (cnt_q != '0);
  assign start = (is_mul(op) || is_div(op)) && !busy;
  assign HI    = hi_q;
  assign LO    = lo_q;

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    if (busy) begin
      // Any op arriving while busy is ignored; the result commits as busy falls.
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else begin
      case (mdu_op_e'(op))
        OpMult, OpMultu: begin
          cnt_d     = CntW'(MULT_CYCLES);
          pend_hi_d = arith_result[63:32];
          pend_lo_d = arith_result[31:0];
        end
        OpDiv, OpDivu: begin
          cnt_d     = CntW'(DIV_CYCLES);
          pend_hi_d = arith_result[63:32];
          pend_lo_d = arith_result[31:0];
        end
        OpMthi:  hi_d = A;
        OpMtlo:  lo_d = A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  always_comb begin
    out = 32'd0;
    case (mdu_op_e'(op))
      OpMfhi:  out = hi_q;
      OpMflo:  out = lo_q;
      default: out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: expected {HI,LO} results are queued at issue
// and popped when busy falls.
module tb_e_mdu;
  import mdu_pkg::*;

  localparam int unsigned MultCycles = 5;
  localparam int unsigned DivCycles  = 10;

  logic        clk;
  logic        reset;
  logic [3:0]  op;
  logic [31:0] A, B;
  logic        start, busy;
  logic [31:0] HI, LO, out;

  int          checks;
  int          failures;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi, m_lo;

  e_mdu #(
    .MULT_CYCLES (MultCycles),
    .DIV_CYCLES  (DivCycles)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .A     (A),
    .B     (B),
    .start (start),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one mult/div for a cycle and queue its expected {HI,LO}.
  task automatic issue_md(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_res);
    @(negedge clk);
    op = o; A = a; B = b;
    #1;
    checks++;
    if (start !== 1'b1) begin
      failures++;
      $display("FAIL start_op%0d: start=%b required 1", o, start);
    end
    exp_q.push_back(exp_res);
    @(negedge clk);
    op = OpNone; A = 32'd0; B = 32'd0;
  endtask

  task automatic issue_mt(input logic [3:0] o, input logic [31:0] a);
    @(negedge clk);
    op = o; A = a;
    @(negedge clk);
    op = OpNone; A = 32'd0;
  endtask

  // Count remaining busy cycles, then compare HI/LO against the queued result.
  task automatic wait_result(input string name, input int exp_cycles);
    int          cycles;
    logic [63:0] e;
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    checks++;
    if (cycles != exp_cycles) begin
      failures++;
      $display("FAIL %s_busy_cycles: got %0d required %0d", name, cycles, exp_cycles);
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s_scoreboard: queue empty, got 0 entries required 1", name);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (HI !== e[63:32]) begin
        failures++;
        $display("FAIL %s_hi: got %h required %h", name, HI, e[63:32]);
      end
      checks++;
      if (LO !== e[31:0]) begin
        failures++;
        $display("FAIL %s_lo: got %h required %h", name, LO, e[31:0]);
      end
      m_hi = e[63:32];
      m_lo = e[31:0];
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    op = OpMfhi;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++;
    if (HI !== 32'd0) begin failures++; $display("FAIL reset_hi: got %h required 0", HI); end
    checks++;
    if (LO !== 32'd0) begin failures++; $display("FAIL reset_lo: got %h required 0", LO); end
    checks++;
    if (out !== 32'd0) begin failures++; $display("FAIL reset_mfhi: got %h required 0", out); end
    op = OpMflo;
    #1;
    checks++;
    if (out !== 32'd0) begin failures++; $display("FAIL reset_mflo: got %h required 0", out); end
    op = OpNone;
    m_hi = 32'd0;
    m_lo = 32'd0;
  endtask

  task automatic test_mult;
    issue_md(OpMult, 32'hffff_fffe, 32'd3, 64'hffff_ffff_ffff_fffa);
    wait_result("mult_neg", MultCycles);
    issue_md(OpMultu, 32'hffff_fffe, 32'd3, 64'h0000_0002_ffff_fffa);
    wait_result("multu", MultCycles);
    issue_md(OpMult, 32'hffff_ffff, 32'hffff_ffff, 64'h0000_0000_0000_0001);
    wait_result("mult_m1", MultCycles);
    issue_md(OpMultu, 32'hffff_ffff, 32'hffff_ffff, 64'hffff_fffe_0000_0001);
    wait_result("multu_max", MultCycles);
  endtask

  task automatic test_div;
    issue_md(OpDiv, 32'hffff_fff9, 32'd2, 64'hffff_ffff_ffff_fffd);
    wait_result("div_neg", DivCycles);
    issue_md(OpDivu, 32'hffff_fff9, 32'd2, 64'h0000_0001_7fff_fffc);
    wait_result("divu", DivCycles);
    issue_md(OpDiv, 32'd7, 32'hffff_fffe, 64'h0000_0001_ffff_fffd);
    wait_result("div_negb", DivCycles);
  endtask

  task automatic test_mt_mf;
    issue_mt(OpMthi, 32'h1234_5678);
    issue_mt(OpMtlo, 32'h9abc_def0);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL mt_busy: got %b required 0", busy); end
    op = OpMfhi;
    #1;
    checks++;
    if (out !== 32'h1234_5678) begin
      failures++; $display("FAIL mfhi: got %h required 12345678", out);
    end
    op = OpMflo;
    #1;
    checks++;
    if (out !== 32'h9abc_def0) begin
      failures++; $display("FAIL mflo: got %h required 9abcdef0", out);
    end
    op = OpMthi;
    #1;
    checks++;
    if (out !== 32'd0) begin failures++; $display("FAIL out_other_op: got %h required 0", out); end
    op = OpNone;
    m_hi = 32'h1234_5678;
    m_lo = 32'h9abc_def0;
  endtask

  task automatic test_ignore_busy;
    issue_md(OpDiv, 32'hffff_fff9, 32'd2, 64'hffff_ffff_ffff_fffd);
    op = OpMult; A = 32'd3; B = 32'd4;
    #1;
    checks++;
    if (start !== 1'b0) begin failures++; $display("FAIL start_busy: got %b required 0", start); end
    @(negedge clk);
    op = OpMthi; A = 32'hdead_beef;
    @(negedge clk);
    op = OpNone; A = 32'd0; B = 32'd0;
    wait_result("div_ignore", DivCycles - 2);
  endtask

  task automatic test_div_bounds;
    issue_mt(OpMtlo, 32'h0000_0055);
    checks++;
    if (LO !== 32'h55) begin failures++; $display("FAIL mtlo_55: got %h required 55", LO); end
    m_lo = 32'h55;
    issue_md(OpDivu, 32'h0000_1234, 32'd0, {m_hi, 32'h55});
    wait_result("divu_zero", DivCycles);
    issue_md(OpDiv, 32'h8765_4321, 32'd0, {m_hi, 32'h55});
    wait_result("div_zero", DivCycles);
    issue_md(OpDiv, 32'h8000_0000, 32'hffff_ffff, 64'h0000_0000_8000_0000);
    wait_result("div_ovf", DivCycles);
  endtask

  task automatic test_reset_mid;
    issue_md(OpDiv, 32'd100, 32'd7, 64'h0000_0002_0000_000e);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL midrst_pre_busy: got %b required 1", busy); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b required 0", busy); end
    checks++;
    if (HI !== 32'd0 || LO !== 32'd0) begin
      failures++; $display("FAIL midrst_hilo: got %h_%h required 0_0", HI, LO);
    end
    repeat (15) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      failures++;
      $display("FAIL midrst_after: got busy=%b hilo=%h_%h required busy=0 hilo=0_0", busy, HI, LO);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    op       = OpNone;
    A        = 32'd0;
    B        = 32'd0;
    test_reset;
    test_mult;
    test_div;
    test_mt_mf;
    test_ignore_busy;
    test_div_bounds;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
